// File: rtl/overcooked_pkg.sv
// Shared game-state definitions for the player controller and the sprite renderer.
package overcooked_pkg;

    localparam int SPRITE_W = 32;
    localparam int SPRITE_H = 32;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    typedef enum logic [1:0] {
        P_LEFT  = 2'd0,
        P_RIGHT = 2'd1,
        P_UP    = 2'd2,
        P_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [3:0] {
        P_NOTHING        = 4'd0,
        P_CHOPPING       = 4'd1,
        P_TOMATO         = 4'd2,
        P_TOMATO_CHOPPED = 4'd3,
        P_ONION          = 4'd4,
        P_ONION_CHOPPED  = 4'd5,
        P_PLATE          = 4'd6,
        P_SOUP_PLATE     = 4'd7,
        P_EXT_OFF        = 4'd8,
        P_EXT_ON         = 4'd9
    } pstate_t;

    // Held-state codes above P_EXT_ON have no meaning and are rejected.
    function automatic logic pstate_legal(input logic [3:0] code);
        return code <= 4'(P_EXT_ON);
    endfunction

endpackage

// File: rtl/edge_pulse.sv
// Registered single-cycle edge detector; DETECT_FALL selects falling or rising edge.
module edge_pulse #(
    parameter logic IDLE_LEVEL  = 1'b0,
    parameter logic DETECT_FALL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sig_in,
    output logic pulse_out
);

    logic sync_q, sync_d;
    logic prev_q, prev_d;

    // Shift the input through two stages so the edge is seen on registered values.
    always_comb begin
        sync_d = sig_in;
        prev_d = sync_q;
    end

    // Stage registers, reset to the idle level so reset release makes no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= IDLE_LEVEL;
            prev_q <= IDLE_LEVEL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    // One-cycle pulse on the selected transition.
    always_comb begin
        if (DETECT_FALL) pulse_out = prev_q & ~sync_q;
        else             pulse_out = sync_q & ~prev_q;
    end

endmodule

// File: rtl/player_controller.sv
// Per-player position, facing and carry/action state, updated on frame ticks.
// Optional: define PLAYER_DIAGONAL_EN to move both axes on the same tick.
module player_controller
    import overcooked_pkg::*;
#(
    parameter int X_INIT      = 64,
    parameter int Y_INIT      = 64,
    parameter int X_MIN       = 0,
    parameter int X_MAX       = SCREEN_W - SPRITE_W,
    parameter int Y_MIN       = 0,
    parameter int Y_MAX       = SCREEN_H - SPRITE_H,
    parameter int STEP        = 2,
    parameter int CHOP_FRAMES = 60
) (
    input  logic        pixel_clk_in,
    input  logic        rst_n_in,
    input  logic        vsync_in,
    input  logic        btn_left_in,
    input  logic        btn_right_in,
    input  logic        btn_up_in,
    input  logic        btn_down_in,
    input  logic        btn_act_in,
    input  logic        btn_use_in,
    input  logic [3:0]  blocked_in,
    output logic        act_valid_out,
    output logic [3:0]  act_state_out,
    input  logic        act_ready_in,
    input  logic        resp_valid_in,
    input  logic [3:0]  resp_state_in,
    output logic [10:0] x_out,
    output logic [9:0]  y_out,
    output logic [1:0]  player_direction_out,
    output logic [3:0]  player_state_out,
    output logic        chop_done_out,
    output logic        busy_out
);

    localparam int CNT_W = $clog2(CHOP_FRAMES + 1);

    typedef enum logic [2:0] {
        S_FREE,
        S_REQ,
        S_WAIT,
        S_CHOP,
        S_SPRAY
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [10:0]      x_q, x_d;
    logic [9:0]       y_q, y_d;
    dir_t             dir_q, dir_d;
    pstate_t          pstate_q, pstate_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             chop_done_q, chop_done_d;

    logic             tick;
    logic             act_rise;

    edge_pulse #(.IDLE_LEVEL(1'b1), .DETECT_FALL(1'b1)) u_vsync_edge (
        .clk       (pixel_clk_in),
        .rst_n     (rst_n_in),
        .sig_in    (vsync_in),
        .pulse_out (tick)
    );

    edge_pulse #(.IDLE_LEVEL(1'b0), .DETECT_FALL(1'b0)) u_act_edge (
        .clk       (pixel_clk_in),
        .rst_n     (rst_n_in),
        .sig_in    (btn_act_in),
        .pulse_out (act_rise)
    );

    logic        dir_any;
    logic        v_act, h_act, do_v, do_h;
    dir_t        v_dir, h_dir;
    logic [10:0] mv_x;
    logic [9:0]  mv_y;
    dir_t        mv_dir;
    int          xi, yi;

    // Candidate position/facing for this tick; applied by the FSM only when movement is allowed.
    always_comb begin
        dir_any = btn_left_in | btn_right_in | btn_up_in | btn_down_in;
        v_act   = btn_up_in ^ btn_down_in;
        h_act   = btn_left_in ^ btn_right_in;
        v_dir   = btn_up_in ? P_UP : P_DOWN;
        h_dir   = btn_left_in ? P_LEFT : P_RIGHT;
        do_v    = v_act;
`ifdef PLAYER_DIAGONAL_EN
        do_h    = h_act;
`else
        do_h    = h_act & ~v_act;
`endif
        mv_x    = x_q;
        mv_y    = y_q;
        mv_dir  = dir_q;
        xi      = int'(x_q);
        yi      = int'(y_q);
        if (do_v) begin
            mv_dir = v_dir;
            if (!blocked_in[v_dir]) begin
                if (v_dir == P_UP) yi = (yi - STEP < Y_MIN) ? Y_MIN : yi - STEP;
                else               yi = (yi + STEP > Y_MAX) ? Y_MAX : yi + STEP;
                mv_y = 10'(yi);
            end
        end
        if (do_h) begin
            if (!do_v) mv_dir = h_dir;
            if (!blocked_in[h_dir]) begin
                if (h_dir == P_LEFT) xi = (xi - STEP < X_MIN) ? X_MIN : xi - STEP;
                else                 xi = (xi + STEP > X_MAX) ? X_MAX : xi + STEP;
                mv_x = 11'(xi);
            end
        end
    end

    // Next-state and action/carry logic.
    always_comb begin
        fsm_d       = fsm_q;
        x_d         = x_q;
        y_d         = y_q;
        dir_d       = dir_q;
        pstate_d    = pstate_q;
        cnt_d       = cnt_q;
        chop_done_d = 1'b0;

        if (tick && (fsm_q == S_FREE || fsm_q == S_SPRAY)) begin
            x_d   = mv_x;
            y_d   = mv_y;
            dir_d = mv_dir;
        end

        case (fsm_q)
            S_FREE: begin
                if (act_rise) begin
                    fsm_d = S_REQ;
                end else if (btn_use_in && pstate_q == P_NOTHING && !dir_any) begin
                    fsm_d    = S_CHOP;
                    pstate_d = P_CHOPPING;
                    cnt_d    = '0;
                end else if (btn_use_in && pstate_q == P_EXT_OFF) begin
                    fsm_d    = S_SPRAY;
                    pstate_d = P_EXT_ON;
                end
            end
            S_REQ: begin
                if (act_ready_in) fsm_d = S_WAIT;
            end
            S_WAIT: begin
                if (resp_valid_in) begin
                    if (pstate_legal(resp_state_in)) pstate_d = pstate_t'(resp_state_in);
                    fsm_d = S_FREE;
                end
            end
            S_CHOP: begin
                if (!btn_use_in || dir_any) begin
                    fsm_d    = S_FREE;
                    pstate_d = P_NOTHING;
                end else if (tick) begin
                    if (cnt_q == CNT_W'(CHOP_FRAMES - 1)) begin
                        fsm_d       = S_FREE;
                        pstate_d    = P_NOTHING;
                        chop_done_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            S_SPRAY: begin
                if (!btn_use_in) begin
                    fsm_d    = S_FREE;
                    pstate_d = P_EXT_OFF;
                end
            end
            default: fsm_d = S_FREE;
        endcase
    end

    // State registers.
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            fsm_q       <= S_FREE;
            x_q         <= 11'(X_INIT);
            y_q         <= 10'(Y_INIT);
            dir_q       <= P_DOWN;
            pstate_q    <= P_NOTHING;
            cnt_q       <= '0;
            chop_done_q <= 1'b0;
        end else begin
            fsm_q       <= fsm_d;
            x_q         <= x_d;
            y_q         <= y_d;
            dir_q       <= dir_d;
            pstate_q    <= pstate_d;
            cnt_q       <= cnt_d;
            chop_done_q <= chop_done_d;
        end
    end

    // Request outputs decode straight from the FSM register so reset drops them at once.
    always_comb begin
        act_valid_out        = (fsm_q == S_REQ);
        act_state_out        = act_valid_out ? 4'(pstate_q) : '0;
        busy_out             = (fsm_q != S_FREE);
        x_out                = x_q;
        y_out                = y_q;
        player_direction_out = 2'(dir_q);
        player_state_out     = 4'(pstate_q);
        chop_done_out        = chop_done_q;
    end

endmodule

// File: tb/tb_player_controller.sv
// Directed scoreboard bench for player_controller.
module tb_player_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        vsync = 1'b1;
    logic        b_l = 1'b0, b_r = 1'b0, b_u = 1'b0, b_d = 1'b0;
    logic        b_act = 1'b0, b_use = 1'b0;
    logic [3:0]  blocked = 4'd0;
    logic        act_valid;
    logic [3:0]  act_state;
    logic        act_ready = 1'b0;
    logic        resp_valid = 1'b0;
    logic [3:0]  resp_state = 4'd0;
    logic [10:0] x;
    logic [9:0]  y;
    logic [1:0]  pdir;
    logic [3:0]  pstate;
    logic        chop_done;
    logic        busy;

    player_controller dut (
        .pixel_clk_in         (clk),
        .rst_n_in             (rst_n),
        .vsync_in             (vsync),
        .btn_left_in          (b_l),
        .btn_right_in         (b_r),
        .btn_up_in            (b_u),
        .btn_down_in          (b_d),
        .btn_act_in           (b_act),
        .btn_use_in           (b_use),
        .blocked_in           (blocked),
        .act_valid_out        (act_valid),
        .act_state_out        (act_state),
        .act_ready_in         (act_ready),
        .resp_valid_in        (resp_valid),
        .resp_state_in        (resp_state),
        .x_out                (x),
        .y_out                (y),
        .player_direction_out (pdir),
        .player_state_out     (pstate),
        .chop_done_out        (chop_done),
        .busy_out             (busy)
    );

    always #5 clk = ~clk;

    int pulses = 0;
    always @(negedge clk) if (chop_done === 1'b1) pulses++;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   passed = 0;
    int   total  = 0;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb_q.size() == 0) begin
            $error("FAIL sb_underflow observed=%0d expected=<entry>", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.val) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One vsync low pulse; the position update lands a couple of cycles after the fall.
    task automatic tick();
        vsync = 1'b0;
        cycles(2);
        vsync = 1'b1;
        cycles(4);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic handshake(input logic [3:0] code);
        b_act = 1'b1;
        cycles(4);
        b_act = 1'b0;
        act_ready = 1'b1;
        cycles(1);
        act_ready = 1'b0;
        resp_valid = 1'b1;
        resp_state = code;
        cycles(1);
        resp_valid = 1'b0;
        cycles(2);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        cycles(3);
        push("rst_x", 64); push("rst_y", 64); push("rst_dir", 3); push("rst_state", 0);
        push("rst_valid", 0); push("rst_busy", 0); push("rst_done", 0); push("rst_astate", 0);
        pop_check(x); pop_check(y); pop_check(pdir); pop_check(pstate);
        pop_check(act_valid); pop_check(busy); pop_check(chop_done); pop_check(act_state);
        rst_n = 1'b1;
        cycles(2);

        // Three ticks right.
        b_r = 1'b1;
        push("right_x", 70); push("right_y", 64); push("right_dir", 1);
        ticks(3);
        b_r = 1'b0;
        pop_check(x); pop_check(y); pop_check(pdir);

        // Left to x=2, then saturate at 0.
        b_l = 1'b1;
        push("left_x2", 2);
        ticks(34);
        pop_check(x);
        push("left_x0", 0); push("left_dir", 0);
        tick();
        pop_check(x); pop_check(pdir);
        push("left_sat", 0);
        tick();
        pop_check(x);
        b_l = 1'b0;

        // Back to x=2, then push left into a wall.
        b_r = 1'b1;
        push("ret_x", 2);
        tick();
        b_r = 1'b0;
        pop_check(x);
        b_l = 1'b1;
        blocked = 4'b0001;
        push("blk_x", 2); push("blk_dir", 0);
        ticks(2);
        pop_check(x); pop_check(pdir);
        b_l = 1'b0;
        blocked = 4'd0;

        // Pick request stalled by act_ready_in low, movement frozen.
        b_act = 1'b1;
        push("req_valid", 1); push("req_astate", 0); push("req_busy", 1);
        cycles(4);
        pop_check(act_valid); pop_check(act_state); pop_check(busy);
        b_act = 1'b0;
        b_r = 1'b1;
        push("req_nomove_x", 2); push("req_hold_valid", 1);
        ticks(5);
        pop_check(x); pop_check(act_valid);
        b_r = 1'b0;
        act_ready = 1'b1;
        cycles(1);
        act_ready = 1'b0;
        push("wait_valid", 0); push("wait_busy", 1);
        cycles(1);
        pop_check(act_valid); pop_check(busy);
        resp_valid = 1'b1;
        resp_state = 4'd2;
        cycles(1);
        resp_valid = 1'b0;
        push("resp_state", 2); push("resp_busy", 0);
        cycles(1);
        pop_check(pstate); pop_check(busy);

        // Stray response outside S_WAIT, then an illegal code: both leave the state alone.
        resp_valid = 1'b1;
        resp_state = 4'd5;
        cycles(1);
        resp_valid = 1'b0;
        push("stray_resp", 2);
        cycles(1);
        pop_check(pstate);
        push("bad_code_state", 2); push("bad_code_busy", 0);
        handshake(4'd12);
        pop_check(pstate); pop_check(busy);
        push("drop_state", 0);
        handshake(4'd0);
        pop_check(pstate);

        // Full chop.
        b_use = 1'b1;
        push("chop_state", 1); push("chop_busy", 1);
        cycles(3);
        pop_check(pstate); pop_check(busy);
        push("chop59_state", 1); push("chop59_pulses", 0);
        ticks(59);
        pop_check(pstate); pop_check(pulses);
        push("chop60_pulses", 1);
        tick();
        pop_check(pulses);
        b_use = 1'b0;
        push("chop_end_state", 0); push("chop_end_busy", 0);
        cycles(3);
        pop_check(pstate); pop_check(busy);

        // Chop aborted at tick 30.
        b_use = 1'b1;
        cycles(3);
        push("abort_mid_state", 1);
        ticks(30);
        pop_check(pstate);
        b_use = 1'b0;
        push("abort_state", 0); push("abort_pulses", 1);
        cycles(3);
        pop_check(pstate); pop_check(pulses);

        // Extinguisher: spray while moving.
        push("ext_off", 8);
        handshake(4'd8);
        pop_check(pstate);
        b_use = 1'b1;
        push("spray_state", 9);
        cycles(3);
        pop_check(pstate);
        b_r = 1'b1;
        push("spray_x", 4); push("spray_dir", 1);
        tick();
        pop_check(x); pop_check(pdir);
        b_r = 1'b0;
        b_use = 1'b0;
        push("spray_end", 8); push("spray_busy", 0);
        cycles(3);
        pop_check(pstate); pop_check(busy);

        // Up + right for one tick.
`ifdef PLAYER_DIAGONAL_EN
        push("ur_x", 6);
`else
        push("ur_x", 4);
`endif
        push("ur_y", 62); push("ur_dir", 2);
        b_u = 1'b1;
        b_r = 1'b1;
        tick();
        b_u = 1'b0;
        b_r = 1'b0;
        pop_check(x); pop_check(y); pop_check(pdir);

        // Reset asserted mid-request drops act_valid_out without waiting for a clock.
        b_act = 1'b1;
        push("pre_rst_valid", 1);
        cycles(4);
        pop_check(act_valid);
        b_act = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        push("async_rst_valid", 0); push("async_rst_x", 64);
        pop_check(act_valid); pop_check(x);
        cycles(2);
        rst_n = 1'b1;
        cycles(2);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
